led7seg_scan_ctrl: RTL and testbench

Time-multiplexing scan controller for a 4-digit common-anode 7-segment display. Holds a 16-bit BCD/hex value, cycles through the four digits at a programmable refresh rate and inserts a blanking dead time between digits to prevent ghosting. It drives the digit nibble and anode pattern consumed by the existing segment decoder/anode-select stage. New values are double-buffered and take effect only at a frame boundary, so a frame never shows a mix of old and new digits.

---
 rtl/led7seg_pkg.sv | 29 ++
 rtl/led7seg_scan_tick_gen.sv | 32 +++
 rtl/led7seg_scan_ctrl.sv | 96 +++++++++
 tb/tb_led7seg_scan_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/led7seg_pkg.sv
// Shared types and helpers for the 4-digit 7-segment scan controller.
package led7seg_pkg;

   localparam int         NUM_DIGITS = 4;
   localparam logic [3:0] AN_OFF     = 4'b1111;

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_ON    = 1'b1
   } scan_state_t;

   // Leading-zero suppression never darkens digit 0, so a value of zero still shows "0".
   function automatic logic digit_dark(input logic [1:0]  idx,
                                       input logic [15:0] val,
                                       input logic [3:0]  mask,
                                       input logic        lz_en);
      logic upper_zero;
      upper_zero = 1'b1;
      for (int j = 0; j < NUM_DIGITS; j++) begin
         if (j >= int'(idx) && val[4*j +: 4] != 4'h0) upper_zero = 1'b0;
      end
      return mask[idx] || (lz_en && idx != 2'd0 && upper_zero);
   endfunction

   function automatic logic [3:0] an_select(input logic [1:0] idx);
      return ~(4'b0001 << idx);
   endfunction

endpackage

// File: rtl/led7seg_scan_tick_gen.sv
// Digit slot counter: wraps every REFRESH_DIV cycles and strobes the blank/slot boundaries.
module scan_tick_gen #(
   parameter int REFRESH_DIV = 100000,
   parameter int BLANK_CYC   = 1000
) (
   input  logic i_clk,
   input  logic i_rst_n,
   output logic o_blank_end,
   output logic o_slot_end,
   output logic o_slot_pre_end
);

   localparam int CW = $clog2(REFRESH_DIV);

   logic [CW-1:0] r_div_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_div_cnt <= '0;
      end else if (o_slot_end) begin
         r_div_cnt <= '0;
      end else begin
         r_div_cnt <= r_div_cnt + CW'(1);
      end
   end

   assign o_blank_end    = (r_div_cnt == CW'(BLANK_CYC - 1));
   assign o_slot_end     = (r_div_cnt == CW'(REFRESH_DIV - 1));
   // One cycle early, so a registered frame_done lines up with the boundary cycle.
   assign o_slot_pre_end = (r_div_cnt == CW'(REFRESH_DIV - 2));

endmodule

// File: rtl/led7seg_scan_ctrl.sv
// Time-multiplexed 4-digit scan with per-slot blanking and frame-aligned double buffering.
// state | meaning:  ST_BLANK | all anodes off, slot dead time   ST_ON | current digit lit
module led7seg_scan_ctrl
   import led7seg_pkg::*;
#(
   parameter int REFRESH_DIV = 100000,
   parameter int BLANK_CYC   = 1000
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [15:0] i_digits_in,
   input  logic        i_load,
   input  logic [3:0]  i_blank_mask,
   input  logic        i_lz_en,
   output logic [3:0]  o_num,
   output logic [3:0]  o_sel_an,
   output logic        o_upd_pend,
   output logic        o_frame_done
);

   scan_state_t r_state, w_state_nxt;
   logic [1:0]  r_idx, w_idx_nxt;
   logic [15:0] r_active, w_active_nxt;
   logic [15:0] r_pending;
   logic        r_upd_pend;
   logic [3:0]  r_num;
   logic [3:0]  r_sel_an;
   logic        r_frame_done;
   logic        w_blank_end, w_slot_end, w_slot_pre_end;
   logic        w_frame_end;

   scan_tick_gen #(
      .REFRESH_DIV (REFRESH_DIV),
      .BLANK_CYC   (BLANK_CYC)
   ) u_tick (
      .i_clk          (i_clk),
      .i_rst_n        (i_rst_n),
      .o_blank_end    (w_blank_end),
      .o_slot_end     (w_slot_end),
      .o_slot_pre_end (w_slot_pre_end)
   );

   always_comb begin
      w_state_nxt  = r_state;
      w_idx_nxt    = r_idx;
      w_active_nxt = r_active;
      case (r_state)
         ST_BLANK: if (w_blank_end) w_state_nxt = ST_ON;
         ST_ON: begin
            if (w_slot_end) begin
               w_state_nxt = ST_BLANK;
               w_idx_nxt   = r_idx + 2'd1;
            end
         end
         default: w_state_nxt = ST_BLANK;
      endcase
      w_frame_end = (r_state == ST_ON) && (r_idx == 2'd3) && w_slot_end;
      // A load on the boundary cycle bypasses the pending register.
      if (w_frame_end) begin
         if (i_load)          w_active_nxt = i_digits_in;
         else if (r_upd_pend) w_active_nxt = r_pending;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= ST_BLANK;
         r_idx        <= 2'd0;
         r_active     <= 16'h0000;
         r_pending    <= 16'h0000;
         r_upd_pend   <= 1'b0;
         r_num        <= 4'h0;
         r_sel_an     <= AN_OFF;
         r_frame_done <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_idx    <= w_idx_nxt;
         r_active <= w_active_nxt;
         if (i_load) r_pending <= i_digits_in;
         if (w_frame_end)  r_upd_pend <= 1'b0;
         else if (i_load)  r_upd_pend <= 1'b1;
         // Outputs are built from next-state values so they move on the same edge as state/idx.
         r_num    <= w_active_nxt[{w_idx_nxt, 2'b00} +: 4];
         r_sel_an <= (w_state_nxt == ST_ON &&
                      !digit_dark(w_idx_nxt, w_active_nxt, i_blank_mask, i_lz_en))
                     ? an_select(w_idx_nxt) : AN_OFF;
         r_frame_done <= w_slot_pre_end && (r_idx == 2'd3);
      end
   end

   assign o_num        = r_num;
   assign o_sel_an     = r_sel_an;
   assign o_upd_pend   = r_upd_pend;
   assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_led7seg_scan_ctrl.sv
// Directed bench for led7seg_scan_ctrl with REFRESH_DIV=8, BLANK_CYC=2 (frame = 32 cycles).
module tb_led7seg_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] digits_in;
   logic        load;
   logic [3:0]  blank_mask;
   logic        lz_en;
   logic [3:0]  num;
   logic [3:0]  sel_an;
   logic        upd_pend;
   logic        frame_done;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   always #5 clk = ~clk;

   led7seg_scan_ctrl #(
      .REFRESH_DIV (8),
      .BLANK_CYC   (2)
   ) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_digits_in  (digits_in),
      .i_load       (load),
      .i_blank_mask (blank_mask),
      .i_lz_en      (lz_en),
      .o_num        (num),
      .o_sel_an     (sel_an),
      .o_upd_pend   (upd_pend),
      .o_frame_done (frame_done)
   );

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic goto_cyc(input int t);
      while (cyc < t) step();
   endtask

   task automatic pulse_load(input logic [15:0] v);
      digits_in = v;
      load      = 1'b1;
      step();
      load      = 1'b0;
   endtask

   task automatic test_reset();
      logic [3:0] exp_sel;
      rst_n = 1'b0; load = 1'b0; digits_in = 16'h0; blank_mask = 4'b0; lz_en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (sel_an !== 4'b1111) begin n_err++; $display("FAIL rst_sel_an: got %b expected 1111", sel_an); end
      n_cmp++; if (num !== 4'h0) begin n_err++; $display("FAIL rst_num: got %h expected 0", num); end
      n_cmp++; if (upd_pend !== 1'b0) begin n_err++; $display("FAIL rst_upd_pend: got %b expected 0", upd_pend); end
      n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL rst_frame_done: got %b expected 0", frame_done); end
      @(negedge clk);
      rst_n = 1'b1;
      cyc   = 0;
      for (int k = 0; k < 32; k++) begin
         if (k > 0) step();
         exp_sel = ((k % 8) < 2) ? 4'b1111 : ~(4'b0001 << (k / 8));
         n_cmp++; if (sel_an !== exp_sel) begin n_err++; $display("FAIL scan_sel_an cyc %0d: got %b expected %b", k, sel_an, exp_sel); end
         n_cmp++; if (num !== 4'h0) begin n_err++; $display("FAIL scan_num cyc %0d: got %h expected 0", k, num); end
         n_cmp++; if (frame_done !== (k == 31)) begin n_err++; $display("FAIL scan_frame_done cyc %0d: got %b expected %b", k, frame_done, (k == 31)); end
      end
   endtask

   task automatic test_load_mid();
      goto_cyc(40);
      pulse_load(16'h1234);
      n_cmp++; if (upd_pend !== 1'b1) begin n_err++; $display("FAIL load_upd_pend_set: got %b expected 1", upd_pend); end
      goto_cyc(50);
      n_cmp++; if (num !== 4'h0) begin n_err++; $display("FAIL load_num_held: got %h expected 0", num); end
      n_cmp++; if (sel_an !== 4'b1011) begin n_err++; $display("FAIL load_sel_d2: got %b expected 1011", sel_an); end
      goto_cyc(63);
      n_cmp++; if (frame_done !== 1'b1) begin n_err++; $display("FAIL load_boundary_fd: got %b expected 1", frame_done); end
      n_cmp++; if (upd_pend !== 1'b1) begin n_err++; $display("FAIL load_pend_at_boundary: got %b expected 1", upd_pend); end
      step();
      n_cmp++; if (upd_pend !== 1'b0) begin n_err++; $display("FAIL load_upd_pend_clr: got %b expected 0", upd_pend); end
      n_cmp++; if (num !== 4'h4) begin n_err++; $display("FAIL load_num_d0: got %h expected 4", num); end
      n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL load_fd_drop: got %b expected 0", frame_done); end
      goto_cyc(66);
      n_cmp++; if (sel_an !== 4'b1110) begin n_err++; $display("FAIL load_sel_d0: got %b expected 1110", sel_an); end
      goto_cyc(72);
      n_cmp++; if (num !== 4'h3) begin n_err++; $display("FAIL load_num_d1: got %h expected 3", num); end
      goto_cyc(80);
      n_cmp++; if (num !== 4'h2) begin n_err++; $display("FAIL load_num_d2: got %h expected 2", num); end
      goto_cyc(88);
      n_cmp++; if (num !== 4'h1) begin n_err++; $display("FAIL load_num_d3: got %h expected 1", num); end
   endtask

   task automatic test_back_to_back();
      goto_cyc(100);
      pulse_load(16'hAAAA);
      goto_cyc(110);
      pulse_load(16'h5A5A);
      n_cmp++; if (upd_pend !== 1'b1) begin n_err++; $display("FAIL b2b_upd_pend: got %b expected 1", upd_pend); end
      goto_cyc(127);
      n_cmp++; if (num !== 4'h1) begin n_err++; $display("FAIL b2b_num_old: got %h expected 1", num); end
      goto_cyc(128);
      n_cmp++; if (num !== 4'hA) begin n_err++; $display("FAIL b2b_num_d0: got %h expected a", num); end
      n_cmp++; if (upd_pend !== 1'b0) begin n_err++; $display("FAIL b2b_upd_pend_clr: got %b expected 0", upd_pend); end
      goto_cyc(136);
      n_cmp++; if (num !== 4'h5) begin n_err++; $display("FAIL b2b_num_d1: got %h expected 5", num); end
      goto_cyc(144);
      n_cmp++; if (num !== 4'hA) begin n_err++; $display("FAIL b2b_num_d2: got %h expected a", num); end
      goto_cyc(152);
      n_cmp++; if (num !== 4'h5) begin n_err++; $display("FAIL b2b_num_d3: got %h expected 5", num); end
      goto_cyc(159);
      n_cmp++; if (frame_done !== 1'b1) begin n_err++; $display("FAIL bypass_fd: got %b expected 1", frame_done); end
      pulse_load(16'h9876);
      n_cmp++; if (num !== 4'h6) begin n_err++; $display("FAIL bypass_num_d0: got %h expected 6", num); end
      n_cmp++; if (upd_pend !== 1'b0) begin n_err++; $display("FAIL bypass_upd_pend: got %b expected 0", upd_pend); end
      goto_cyc(168);
      n_cmp++; if (num !== 4'h7) begin n_err++; $display("FAIL bypass_num_d1: got %h expected 7", num); end
   endtask

   task automatic test_lz();
      goto_cyc(170);
      lz_en = 1'b1;
      pulse_load(16'h0030);
      goto_cyc(196);
      n_cmp++; if (sel_an !== 4'b1110) begin n_err++; $display("FAIL lz30_d0: got %b expected 1110", sel_an); end
      goto_cyc(204);
      n_cmp++; if (sel_an !== 4'b1101) begin n_err++; $display("FAIL lz30_d1: got %b expected 1101", sel_an); end
      n_cmp++; if (num !== 4'h3) begin n_err++; $display("FAIL lz30_num_d1: got %h expected 3", num); end
      goto_cyc(212);
      n_cmp++; if (sel_an !== 4'b1111) begin n_err++; $display("FAIL lz30_d2: got %b expected 1111", sel_an); end
      goto_cyc(220);
      n_cmp++; if (sel_an !== 4'b1111) begin n_err++; $display("FAIL lz30_d3: got %b expected 1111", sel_an); end
      goto_cyc(224);
      pulse_load(16'h0000);
      goto_cyc(260);
      n_cmp++; if (sel_an !== 4'b1110) begin n_err++; $display("FAIL lz0_d0: got %b expected 1110", sel_an); end
      goto_cyc(268);
      n_cmp++; if (sel_an !== 4'b1111) begin n_err++; $display("FAIL lz0_d1: got %b expected 1111", sel_an); end
      goto_cyc(276);
      n_cmp++; if (sel_an !== 4'b1111) begin n_err++; $display("FAIL lz0_d2: got %b expected 1111", sel_an); end
      goto_cyc(284);
      n_cmp++; if (sel_an !== 4'b1111) begin n_err++; $display("FAIL lz0_d3: got %b expected 1111", sel_an); end
      goto_cyc(287);
      lz_en = 1'b0;
   endtask

   task automatic test_mask();
      goto_cyc(288);
      blank_mask = 4'b0100;
      goto_cyc(292);
      n_cmp++; if (sel_an !== 4'b1110) begin n_err++; $display("FAIL mask_d0: got %b expected 1110", sel_an); end
      goto_cyc(300);
      n_cmp++; if (sel_an !== 4'b1101) begin n_err++; $display("FAIL mask_d1: got %b expected 1101", sel_an); end
      goto_cyc(308);
      n_cmp++; if (sel_an !== 4'b1111) begin n_err++; $display("FAIL mask_d2: got %b expected 1111", sel_an); end
      goto_cyc(316);
      n_cmp++; if (sel_an !== 4'b0111) begin n_err++; $display("FAIL mask_d3: got %b expected 0111", sel_an); end
      goto_cyc(320);
      blank_mask = 4'b0000;
   endtask

   task automatic test_reset_midslot();
      goto_cyc(322);
      pulse_load(16'h1234);
      goto_cyc(354);
      pulse_load(16'h5555);
      goto_cyc(372);
      n_cmp++; if (sel_an !== 4'b1011) begin n_err++; $display("FAIL pre_rst_sel: got %b expected 1011", sel_an); end
      n_cmp++; if (num !== 4'h2) begin n_err++; $display("FAIL pre_rst_num: got %h expected 2", num); end
      n_cmp++; if (upd_pend !== 1'b1) begin n_err++; $display("FAIL pre_rst_pend: got %b expected 1", upd_pend); end
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++; if (sel_an !== 4'b1111) begin n_err++; $display("FAIL async_rst_sel: got %b expected 1111", sel_an); end
      n_cmp++; if (num !== 4'h0) begin n_err++; $display("FAIL async_rst_num: got %h expected 0", num); end
      n_cmp++; if (upd_pend !== 1'b0) begin n_err++; $display("FAIL async_rst_pend: got %b expected 0", upd_pend); end
      @(negedge clk);
      rst_n = 1'b1;
      cyc   = 0;
      n_cmp++; if (upd_pend !== 1'b0) begin n_err++; $display("FAIL rel_pend: got %b expected 0", upd_pend); end
      goto_cyc(1);
      n_cmp++; if (sel_an !== 4'b1111) begin n_err++; $display("FAIL rel_blank: got %b expected 1111", sel_an); end
      goto_cyc(2);
      n_cmp++; if (sel_an !== 4'b1110) begin n_err++; $display("FAIL rel_d0_on: got %b expected 1110", sel_an); end
      n_cmp++; if (num !== 4'h0) begin n_err++; $display("FAIL rel_num: got %h expected 0", num); end
      goto_cyc(34);
      n_cmp++; if (num !== 4'h0) begin n_err++; $display("FAIL rel_next_frame_num: got %h expected 0", num); end
      n_cmp++; if (upd_pend !== 1'b0) begin n_err++; $display("FAIL rel_next_frame_pend: got %b expected 0", upd_pend); end
   endtask

   initial begin
      test_reset();
      test_load_mid();
      test_back_to_back();
      test_lz();
      test_mask();
      test_reset_midslot();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
